// File: rtl/syn_fft_pkg.sv
// Shared types and default sizing for the in-place radix-2 DIT FFT sequencer.
package syn_fft_pkg;

   localparam int P_FFT_N     = 128;
   localparam int P_FFT_LOG2N = 7;
   localparam int P_MAX_OUTST = 8;

   // One complex sample word: {re[15:0], im[15:0]}
   typedef logic [31:0] fft_sample_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } fft_sched_st_t;

endpackage

// File: rtl/syn_fft_sched_if.sv
// Control and datapath handshake bundle between the FFT sequencer and the butterfly/RAM side.
// fft_abort_i exists only when SYN_FFT_ABORT_EN is defined.
interface syn_fft_sched_if #(
   parameter int P_FFT_LOG2N = syn_fft_pkg::P_FFT_LOG2N
);
   logic                   fft_start_i;
   logic                   fft_busy_o;
   logic                   fft_done_o;
   logic                   but_issue_o;
   logic                   but_rdy_i;
   logic [P_FFT_LOG2N-1:0] rd_addr_a_o;
   logic [P_FFT_LOG2N-1:0] rd_addr_b_o;
   logic [P_FFT_LOG2N-2:0] twdl_addr_o;
   logic                   but_res_valid_i;
   logic                   wr_en_o;
   logic [P_FFT_LOG2N-1:0] wr_addr_a_o;
   logic [P_FFT_LOG2N-1:0] wr_addr_b_o;
   logic [P_FFT_LOG2N-1:0] stage_o;
`ifdef SYN_FFT_ABORT_EN
   logic                   fft_abort_i;
`endif

   // master: the sequencer; slave: top-level control plus butterfly datapath
   modport master (
`ifdef SYN_FFT_ABORT_EN
      input  fft_abort_i,
`endif
      input  fft_start_i, but_rdy_i, but_res_valid_i,
      output fft_busy_o, fft_done_o, but_issue_o, rd_addr_a_o, rd_addr_b_o,
             twdl_addr_o, wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o
   );

   modport slave (
`ifdef SYN_FFT_ABORT_EN
      output fft_abort_i,
`endif
      output fft_start_i, but_rdy_i, but_res_valid_i,
      input  fft_busy_o, fft_done_o, but_issue_o, rd_addr_a_o, rd_addr_b_o,
             twdl_addr_o, wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o
   );

endinterface

// File: rtl/syn_fft_wb_fifo.sv
// Writeback address FIFO: holds {a,b} of each in-flight butterfly, head visible without latency.
module syn_fft_wb_fifo #(
   parameter int P_WIDTH = 14,
   parameter int P_DEPTH = 8
) (
   input  logic               clk_ir,
   input  logic               rst_il,
   input  logic               push,
   input  logic [P_WIDTH-1:0] push_data,
   input  logic               pop,
   output logic [P_WIDTH-1:0] pop_data,
   output logic               empty,
   output logic               full
);
   localparam int PW = $clog2(P_DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [PW:0]        wr_ptr_reg;
   logic [PW:0]        rd_ptr_reg;
   logic               do_push;
   logic               do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr_reg[PW-1:0]];

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge clk_ir) begin
      if (do_push) mem[wr_ptr_reg[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/syn_fft_sched.sv
// In-place radix-2 DIT FFT butterfly sequencer with a stage barrier between passes.
// Optional SYN_FFT_ABORT_EN adds fft_abort_i: stop issuing, drain, return to IDLE without done.
module syn_fft_sched #(
   parameter int P_FFT_N     = syn_fft_pkg::P_FFT_N,
   parameter int P_FFT_LOG2N = syn_fft_pkg::P_FFT_LOG2N,
   parameter int P_MAX_OUTST = syn_fft_pkg::P_MAX_OUTST
) (
   input logic             clk_ir,
   input logic             rst_il,
   syn_fft_sched_if.master bus
);
   import syn_fft_pkg::*;

   localparam int AW = P_FFT_LOG2N;
   localparam int KW = P_FFT_LOG2N - 1;
   localparam int OW = $clog2(P_MAX_OUTST) + 1;
   localparam logic [KW-1:0] K_LAST = KW'(P_FFT_N/2 - 1);
   localparam logic [AW-1:0] S_LAST = AW'(P_FFT_LOG2N - 1);
   localparam logic [OW-1:0] O_MAX  = OW'(P_MAX_OUTST);

   fft_sched_st_t  state_reg, state_next;
   logic [AW-1:0]  stage_reg, stage_next;
   logic [KW-1:0]  k_reg, k_next;
   logic [OW-1:0]  outst_reg, outst_next;
   logic           abort_reg, abort_next;
   logic           issue_reg, issue_next;
   logic [AW-1:0]  addr_a_reg, addr_a_next;
   logic [AW-1:0]  addr_b_reg, addr_b_next;
   logic [KW-1:0]  twdl_reg, twdl_next;

   logic           abort_req;
   logic           fire;
   logic           push;
   logic           pop;
   logic           empty;
   logic           full;
   logic [2*AW-1:0] head;
   logic [AW-1:0]  k_ext, span, pos, grp, gen_a, gen_b;
   logic [KW-1:0]  gen_t;

`ifdef SYN_FFT_ABORT_EN
   assign abort_req = bus.fft_abort_i;
`else
   assign abort_req = 1'b0;
`endif

   // Abort masks the registered valid in the same cycle so nothing more is accepted
   assign bus.but_issue_o = issue_reg & ~abort_req;
   assign fire            = bus.but_issue_o & bus.but_rdy_i;
   assign push            = fire & ~full;
   assign pop             = bus.but_res_valid_i & ~empty;

   always_comb begin
      state_next = state_reg;
      stage_next = stage_reg;
      k_next     = k_reg;
      abort_next = abort_reg;
      unique case ({push, pop})
         2'b10:   outst_next = outst_reg + OW'(1);
         2'b01:   outst_next = outst_reg - OW'(1);
         default: outst_next = outst_reg;
      endcase
      case (state_reg)
         IDLE: begin
            if (bus.fft_start_i) begin
               state_next = ISSUE;
               stage_next = '0;
               k_next     = '0;
               abort_next = 1'b0;
            end
         end
         ISSUE: begin
            if (abort_req) begin
               state_next = DRAIN;
               abort_next = 1'b1;
            end else if (fire) begin
               if (k_reg == K_LAST) state_next = DRAIN;
               else                 k_next     = k_reg + KW'(1);
            end
         end
         DRAIN: begin
            abort_next = abort_reg | abort_req;
            // Barrier: next stage reads only after every result of this stage is written
            if (outst_reg == '0) begin
               if (abort_reg || abort_req) begin
                  state_next = IDLE;
               end else if (stage_reg == S_LAST) begin
                  state_next = DONE;
               end else begin
                  state_next = ISSUE;
                  stage_next = stage_reg + AW'(1);
                  k_next     = '0;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      k_ext = AW'(k_next);
      span  = AW'(1) << stage_next;
      pos   = k_ext & (span - AW'(1));
      grp   = k_ext >> stage_next;
      gen_a = (grp << (stage_next + AW'(1))) | pos;
      gen_b = gen_a + span;
      gen_t = KW'(pos << (S_LAST - stage_next));
   end

   always_comb begin
      issue_next  = (state_next == ISSUE) && (outst_next != O_MAX);
      addr_a_next = '0;
      addr_b_next = '0;
      twdl_next   = '0;
      if (state_next == ISSUE) begin
         addr_a_next = gen_a;
         addr_b_next = gen_b;
         twdl_next   = gen_t;
      end
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         state_reg  <= IDLE;
         stage_reg  <= '0;
         k_reg      <= '0;
         outst_reg  <= '0;
         abort_reg  <= 1'b0;
         issue_reg  <= 1'b0;
         addr_a_reg <= '0;
         addr_b_reg <= '0;
         twdl_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         stage_reg  <= stage_next;
         k_reg      <= k_next;
         outst_reg  <= outst_next;
         abort_reg  <= abort_next;
         issue_reg  <= issue_next;
         addr_a_reg <= addr_a_next;
         addr_b_reg <= addr_b_next;
         twdl_reg   <= twdl_next;
      end
   end

   syn_fft_wb_fifo #(
      .P_WIDTH (2*AW),
      .P_DEPTH (P_MAX_OUTST)
   ) u_wb_fifo (
      .clk_ir    (clk_ir),
      .rst_il    (rst_il),
      .push      (push),
      .push_data ({addr_a_reg, addr_b_reg}),
      .pop       (pop),
      .pop_data  (head),
      .empty     (empty),
      .full      (full)
   );

   assign bus.fft_busy_o  = (state_reg == ISSUE) || (state_reg == DRAIN);
   assign bus.fft_done_o  = (state_reg == DONE);
   assign bus.rd_addr_a_o = addr_a_reg;
   assign bus.rd_addr_b_o = addr_b_reg;
   assign bus.twdl_addr_o = twdl_reg;
   assign bus.stage_o     = stage_reg;
   assign bus.wr_en_o     = pop;
   assign bus.wr_addr_a_o = pop ? head[2*AW-1:AW] : '0;
   assign bus.wr_addr_b_o = pop ? head[AW-1:0]    : '0;

   // A result with nothing in flight is a datapath protocol error; it is dropped
   res_without_issue: assert property (
      @(posedge clk_ir) disable iff (!rst_il) !(bus.but_res_valid_i && empty)
   );

endmodule
